// File: rtl/if_fetch_req.sv
// Fetch request generator: keeps a PC, issues word reads under a credit limit, pairs each
// response with its snpc and buffers it for IF. Optional perf counters under FETCH_PERF_EN.
module if_fetch_req #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_opt,
  input  logic [31:0] redirect_pc,
  output logic        mem_ar_valid,
  input  logic        mem_ar_ready,
  output logic [31:0] mem_ar_addr,
  input  logic        mem_r_valid,
  input  logic [31:0] mem_r_data,
  output logic        mem_r_ready,
  output logic        AR_valid,
  output logic [31:0] AR_inst,
  output logic [31:0] PC_snpc,
  input  logic        IF_ready,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_drop
);

  localparam int unsigned   PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   CW       = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(DEPTH);

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == LAST_PTR) ptr_next = '0;
    else               ptr_next = p + PW'(1);
  endfunction

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [PW-1:0] tag_wp_q, tag_wp_d, tag_rp_q, tag_rp_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [31:0]   tag_mem_q  [DEPTH];
  logic [31:0]   buf_inst_q [DEPTH];
  logic [31:0]   buf_snpc_q [DEPTH];

  logic ar_hs_s, discard_s, push_s, pop_s;

  // A response is discarded while drops are owed or when a redirect lands on it.
  assign ar_hs_s      = mem_ar_valid & mem_ar_ready;
  assign discard_s    = mem_r_valid & (pc_opt | (drop_q != '0));
  assign push_s       = mem_r_valid & ~discard_s;
  assign pop_s        = AR_valid & IF_ready;

  assign mem_ar_valid = rst & (({1'b0, inflight_q} + {1'b0, count_q}) < DEPTH_C);
  assign mem_ar_addr  = pc_q;
  assign mem_r_ready  = 1'b1;
  assign AR_valid     = (count_q != '0);
  assign AR_inst      = AR_valid ? buf_inst_q[head_q] : 32'h0000_0000;
  assign PC_snpc      = AR_valid ? buf_snpc_q[head_q] : 32'h0000_0000;

  // Next-state for PC, credit counters, drop tracking and queue pointers.
  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q + CW'(ar_hs_s) - CW'(mem_r_valid);
    count_d    = count_q;
    drop_d     = drop_q;
    tag_wp_d   = ar_hs_s ? ptr_next(tag_wp_q) : tag_wp_q;
    tag_rp_d   = mem_r_valid ? ptr_next(tag_rp_q) : tag_rp_q;
    head_d     = head_q;
    tail_d     = tail_q;
    if (pc_opt) begin
      // Every fetch still outstanding after this edge belongs to the old path.
      pc_d    = redirect_pc & 32'hFFFF_FFFC;
      drop_d  = inflight_d;
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      pc_d    = ar_hs_s ? (pc_q + 32'd4) : pc_q;
      count_d = count_q + CW'(push_s) - CW'(pop_s);
      head_d  = pop_s ? ptr_next(head_q) : head_q;
      tail_d  = push_s ? ptr_next(tail_q) : tail_q;
      if (mem_r_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
      else                               drop_d = drop_q;
    end
  end

  // State registers plus tag queue and response buffer storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      count_q    <= '0;
      drop_q     <= '0;
      tag_wp_q   <= '0;
      tag_rp_q   <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        tag_mem_q[i]  <= 32'h0000_0000;
        buf_inst_q[i] <= 32'h0000_0000;
        buf_snpc_q[i] <= 32'h0000_0000;
      end
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      drop_q     <= drop_d;
      tag_wp_q   <= tag_wp_d;
      tag_rp_q   <= tag_rp_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      if (ar_hs_s) tag_mem_q[tag_wp_q] <= pc_q;
      if (push_s) begin
        buf_inst_q[tail_q] <= mem_r_data;
        buf_snpc_q[tail_q] <= tag_mem_q[tag_rp_q] + 32'd4;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_drop_q;

  // Saturating delivery and discard counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_q <= 32'h0000_0000;
      perf_drop_q  <= 32'h0000_0000;
    end else begin
      if (pop_s && !pc_opt && (perf_fetch_q != 32'hFFFF_FFFF)) perf_fetch_q <= perf_fetch_q + 32'd1;
      if (discard_s && (perf_drop_q != 32'hFFFF_FFFF))         perf_drop_q  <= perf_drop_q + 32'd1;
    end
  end

  assign perf_fetch = perf_fetch_q;
  assign perf_drop  = perf_drop_q;
`else
  assign perf_fetch = 32'h0000_0000;
  assign perf_drop  = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_if_fetch_req.sv
// Directed bench for if_fetch_req: stimulus pushes expected deliveries into a scoreboard,
// a monitor pops and compares on every IF handshake; memory model has 1-cycle latency.
module tb_if_fetch_req;
  localparam int unsigned TB_DEPTH = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pc_opt = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        mem_ar_valid;
  logic        mem_ar_ready = 1'b0;
  logic [31:0] mem_ar_addr;
  logic        mem_r_valid = 1'b0;
  logic [31:0] mem_r_data = 32'h0;
  logic        mem_r_ready;
  logic        AR_valid;
  logic [31:0] AR_inst;
  logic [31:0] PC_snpc;
  logic        IF_ready = 1'b0;
  logic [31:0] perf_fetch;
  logic [31:0] perf_drop;

  if_fetch_req #(.RESET_PC(32'h8000_0000), .DEPTH(TB_DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_opt(pc_opt), .redirect_pc(redirect_pc),
    .mem_ar_valid(mem_ar_valid), .mem_ar_ready(mem_ar_ready), .mem_ar_addr(mem_ar_addr),
    .mem_r_valid(mem_r_valid), .mem_r_data(mem_r_data), .mem_r_ready(mem_r_ready),
    .AR_valid(AR_valid), .AR_inst(AR_inst), .PC_snpc(PC_snpc), .IF_ready(IF_ready),
    .perf_fetch(perf_fetch), .perf_drop(perf_drop)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int pops = 0;
  int hs_cnt = 0;
  logic [63:0] expq[$];
  logic [31:0] memq[$];
  logic        pend_v = 1'b0;
  logic [31:0] pend_a = 32'h0;
  logic        hold = 1'b0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] perf_exp(input logic [31:0] v);
`ifdef FETCH_PERF_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic exp_push(input logic [31:0] addr);
    expq.push_back({inst_of(addr), addr + 32'd4});
  endtask

  // Called at a negedge with final inputs: retire consumed response, accept the handshake
  // seen last cycle, predict this cycle's handshake, present the next response.
  task automatic mem_model();
    if (mem_r_valid) void'(memq.pop_front());
    if (pend_v) memq.push_back(pend_a);
    pend_v = mem_ar_valid & mem_ar_ready;
    pend_a = mem_ar_addr;
    if (pend_v) hs_cnt++;
    if (!hold && memq.size() != 0) begin
      mem_r_valid = 1'b1;
      mem_r_data  = inst_of(memq[0]);
    end else begin
      mem_r_valid = 1'b0;
      mem_r_data  = 32'h0;
    end
  endtask

  task automatic cyc();
    mem_model();
    @(negedge clk);
  endtask

  // Monitor: a pop happens at the coming posedge when AR_valid & IF_ready without redirect.
  always begin
    @(negedge clk);
    #1;
    if (rst && AR_valid && IF_ready && !pc_opt) begin
      if (expq.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_delivery: got inst %h snpc %h expected none", AR_inst, PC_snpc);
      end else begin
        logic [63:0] e;
        e = expq.pop_front();
        chk("deliver_inst", AR_inst, e[63:32]);
        chk("deliver_snpc", PC_snpc, e[31:0]);
        pops++;
      end
    end
  end

  initial begin
    int cnt;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ar_valid", {31'd0, mem_ar_valid}, 32'd0);
    chk("rst_AR_valid", {31'd0, AR_valid}, 32'd0);
    chk("rst_AR_inst", AR_inst, 32'h0);
    chk("rst_PC_snpc", PC_snpc, 32'h0);
    chk("rst_perf_fetch", perf_fetch, 32'h0);
    chk("rst_perf_drop", perf_drop, 32'h0);
    rst = 1'b1;
    cyc();
    chk("first_ar_valid", {31'd0, mem_ar_valid}, 32'd1);
    chk("first_ar_addr", mem_ar_addr, 32'h8000_0000);
    chk("first_AR_valid", {31'd0, AR_valid}, 32'd0);
    cyc();
    chk("hold_ar_valid", {31'd0, mem_ar_valid}, 32'd1);
    chk("hold_ar_addr", mem_ar_addr, 32'h8000_0000);
    chk("mem_r_ready", {31'd0, mem_r_ready}, 32'd1);

    // Streaming: 8 fetches, one delivery per cycle
    for (int i = 0; i < 8; i++) exp_push(32'h8000_0000 + 32'(4 * i));
    hs_cnt = 0; cnt = 0;
    mem_ar_ready = 1'b1; IF_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (i >= 1 && AR_valid) cnt++;
    end
    mem_ar_ready = 1'b0;
    repeat (4) cyc();
    chk("stream_handshakes", 32'(hs_cnt), 32'd8);
    chk("stream_sustained", 32'(cnt), 32'd7);
    chk("stream_all_delivered", 32'(expq.size()), 32'd0);

    // Backpressure: IF stalled for 8 cycles
    exp_push(32'h8000_0020); exp_push(32'h8000_0024); exp_push(32'h8000_0028);
    hs_cnt = 0;
    mem_ar_ready = 1'b1; IF_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (i >= 2) begin
        chk("bp_AR_valid", {31'd0, AR_valid}, 32'd1);
        chk("bp_head_inst", AR_inst, inst_of(32'h8000_0020));
        chk("bp_head_snpc", PC_snpc, 32'h8000_0024);
      end
    end
    chk("bp_handshakes", 32'(hs_cnt), 32'(TB_DEPTH));
    chk("bp_credit_closed", {31'd0, mem_ar_valid}, 32'd0);
    mem_ar_ready = 1'b0; IF_ready = 1'b1;
    repeat (5) cyc();
    chk("bp_all_delivered", 32'(expq.size()), 32'd0);

    // Redirect with two fetches in flight
    hold = 1'b1; mem_ar_ready = 1'b1;
    repeat (2) cyc();
    mem_ar_ready = 1'b0; pc_opt = 1'b1; redirect_pc = 32'h8000_0102;
    cyc();
    pc_opt = 1'b0;
    chk("redir_ar_addr", mem_ar_addr, 32'h8000_0100);
    chk("redir_AR_valid", {31'd0, AR_valid}, 32'd0);
    hold = 1'b0;
    repeat (3) cyc();
    chk("redir_dropped_AR_valid", {31'd0, AR_valid}, 32'd0);
    chk("redir_perf_drop", perf_drop, perf_exp(32'd2));
    exp_push(32'h8000_0100);
    mem_ar_ready = 1'b1;
    cyc();
    mem_ar_ready = 1'b0;
    repeat (3) cyc();
    chk("redir_target_delivered", 32'(expq.size()), 32'd0);

    // Redirect coinciding with a response and an AR handshake
    exp_push(32'h8000_0104);
    mem_ar_ready = 1'b1; IF_ready = 1'b1;
    repeat (3) cyc();
    pc_opt = 1'b1; redirect_pc = 32'h8000_0200;
    cyc();
    pc_opt = 1'b0; mem_ar_ready = 1'b0;
    chk("coll_ar_addr", mem_ar_addr, 32'h8000_0200);
    chk("coll_AR_valid", {31'd0, AR_valid}, 32'd0);
    repeat (2) cyc();
    chk("coll_AR_valid_after", {31'd0, AR_valid}, 32'd0);
    chk("coll_perf_drop", perf_drop, perf_exp(32'd4));
    chk("coll_perf_fetch", perf_fetch, perf_exp(32'(pops)));
    exp_push(32'h8000_0200);
    mem_ar_ready = 1'b1;
    cyc();
    mem_ar_ready = 1'b0;
    repeat (3) cyc();
    chk("coll_target_delivered", 32'(expq.size()), 32'd0);

    // Asynchronous reset between edges
    mem_ar_ready = 1'b1; IF_ready = 1'b0;
    repeat (2) cyc();
    mem_ar_ready = 1'b0;
    cyc();
    chk("pre_rst_AR_valid", {31'd0, AR_valid}, 32'd1);
    chk("pre_rst_AR_inst", AR_inst, inst_of(32'h8000_0204));
    #2 rst = 1'b0;
    #1;
    chk("arst_ar_valid", {31'd0, mem_ar_valid}, 32'd0);
    chk("arst_AR_valid", {31'd0, AR_valid}, 32'd0);
    chk("arst_AR_inst", AR_inst, 32'h0);
    chk("arst_PC_snpc", PC_snpc, 32'h0);
    chk("arst_perf_fetch", perf_fetch, 32'h0);
    chk("arst_perf_drop", perf_drop, 32'h0);
    memq.delete(); pend_v = 1'b0; mem_r_valid = 1'b0; mem_r_data = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    cyc();
    chk("restart_ar_addr", mem_ar_addr, 32'h8000_0000);
    chk("restart_ar_valid", {31'd0, mem_ar_valid}, 32'd1);
    exp_push(32'h8000_0000);
    mem_ar_ready = 1'b1; IF_ready = 1'b1;
    cyc();
    mem_ar_ready = 1'b0;
    repeat (3) cyc();
    chk("restart_delivered", 32'(expq.size()), 32'd0);
    chk("restart_perf_drop", perf_drop, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
